// File: rtl/k12a_lcd_ctrl.sv
// k12a_lcd_ctrl
// Bus sequencer for the HD44780-style character LCD on the k12a I/O bus.
// Turns single-cycle read/write requests from the I/O decoder into timed
// RS/RW/EN/DATA panel transactions. After each write it waits for the panel
// to finish executing the command. 'ready' tells the decoder when a new
// request will be taken.
//
// Ports:
//   cpu_clock      - sole clock, rising edge
//   reset          - synchronous, active-high
//   wr_req/rd_req  - request pulses, honoured only while ready=1 (write wins)
//   req_rs         - RS for the request (0 = command/status, 1 = data)
//   wr_data        - byte to write
//   ready          - idle, next request will be accepted
//   rd_data        - last byte read from the panel
//   rd_valid       - one-cycle pulse when rd_data updates
//   overrun        - one-cycle pulse when a request arrived while busy
//   lcd_rs/lcd_rw/lcd_en - panel control pins
//   lcd_data_out/lcd_data_oe - panel data drive value and its output enable
//   lcd_data_in    - panel data as sampled from the pins
module k12a_lcd_ctrl #(
  parameter int SETUP_CYCLES     = 1,
  parameter int EN_CYCLES        = 3,
  parameter int HOLD_CYCLES      = 1,
  parameter int EXEC_CYCLES      = 40,
  parameter int LONG_EXEC_CYCLES = 1600
) (
  input  logic       cpu_clock,
  input  logic       reset,
  input  logic       wr_req,
  input  logic       rd_req,
  input  logic       req_rs,
  input  logic [7:0] wr_data,
  output logic       ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       overrun,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  input  logic [7:0] lcd_data_in
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One shared down-counter times every phase, so it must hold the longest wait.
  localparam int MAX_CYCLES = max2(max2(max2(SETUP_CYCLES, EN_CYCLES),
                                        max2(HOLD_CYCLES, EXEC_CYCLES)),
                                   LONG_EXEC_CYCLES);
  localparam int CNT_W = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] SETUP_LOAD     = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] EN_LOAD        = CNT_W'(EN_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD      = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] EXEC_LOAD      = CNT_W'(EXEC_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_EXEC_LOAD = CNT_W'(LONG_EXEC_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ENABLE,
    HOLD,
    EXEC
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             rs_q;
  logic             rw_q;
  logic [7:0]       data_q;
  logic             req_any;
  logic             accept;
  logic             cnt_done;
  logic             long_exec;
  logic             bus_active;

  assign req_any  = wr_req | rd_req;
  assign accept   = (state == IDLE) && req_any;
  assign cnt_done = (cnt == '0);

  // Clear (0x01) and return-home (0x02/0x03) take far longer to execute than
  // any other instruction. Command 0x00 is not one of them.
  assign long_exec = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);

  // State and phase counter register.
  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: each timed phase loads the counter with its length
  // minus one on entry and moves on when the counter has run down to zero.
  // The pin values are decoded from the registered state and latched request.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    bus_active   = 1'b0;
    ready        = 1'b0;
    lcd_en       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (req_any) begin
          state_nxt = SETUP;
          cnt_nxt   = SETUP_LOAD;
        end
      end
      SETUP: begin
        bus_active = 1'b1;
        if (cnt_done) begin
          state_nxt = ENABLE;
          cnt_nxt   = EN_LOAD;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      ENABLE: begin
        bus_active = 1'b1;
        lcd_en     = 1'b1;
        if (cnt_done) begin
          state_nxt = HOLD;
          cnt_nxt   = HOLD_LOAD;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      HOLD: begin
        bus_active = 1'b1;
        if (cnt_done) begin
          if (rw_q) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            state_nxt = EXEC;
            cnt_nxt   = long_exec ? LONG_EXEC_LOAD : EXEC_LOAD;
          end
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      EXEC: begin
        if (cnt_done) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // RS and the data byte stay on the pins after the transaction, which keeps
  // the panel inputs quiet. RW and the data drive are released outside the
  // bus phases so the panel is never driven against during EXEC.
  assign lcd_rs       = rs_q;
  assign lcd_data_out = data_q;
  assign lcd_rw       = bus_active & rw_q;
  assign lcd_data_oe  = bus_active & ~rw_q;

  // Request latch, read capture and the two status pulses. The read byte is
  // sampled on the last EN-high cycle, the point where panel data is settled.
  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      rs_q     <= 1'b0;
      rw_q     <= 1'b0;
      data_q   <= 8'h00;
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (accept) begin
        rs_q   <= req_rs;
        rw_q   <= ~wr_req;
        data_q <= wr_data;
      end
      if ((state == ENABLE) && cnt_done && rw_q) begin
        rd_data <= lcd_data_in;
      end
      rd_valid <= (state == HOLD) && cnt_done && rw_q;
      overrun  <= (state != IDLE) && req_any;
    end
  end

endmodule

// File: doc/k12a_lcd_ctrl.md
# k12a_lcd_ctrl

Bus sequencer for the HD44780-style character LCD on the k12a I/O bus. It accepts single-cycle write and read requests from the CPU-side I/O decoder. Each request becomes a correctly timed RS/RW/EN/DATA transaction, with a command-execution wait after writes. It sits between the I/O register decoder and the `lcd_rs`/`lcd_rw`/`lcd_en`/`lcd_data` top-level pins, and reports `ready` so software or the decoder never violates panel timing.

## Interface
- `SETUP_CYCLES`, 1: cycles RS/RW/DATA are stable before EN rises (≥1).
- `EN_CYCLES`, 3: cycles EN is held high (≥1).
- `HOLD_CYCLES`, 1: cycles RS/RW/DATA are held after EN falls (≥1).
- `EXEC_CYCLES`, 40: post-write wait for normal commands and data (≥1).
- `LONG_EXEC_CYCLES`, 1600: post-write wait for clear and home commands (≥1).
- `cpu_clock` in 1: sole clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `wr_req` in 1: write request pulse; qualified by `ready`.
- `rd_req` in 1: read request pulse; qualified by `ready`.
- `req_rs` in 1: RS value for the request (0 = command/status, 1 = data).
- `wr_data` in 8: byte to write.
- `ready` out 1: high when idle and a request will be accepted.
- `rd_data` out 8: last byte read from the panel.
- `rd_valid` out 1: one-cycle pulse when `rd_data` updates.
- `overrun` out 1: one-cycle pulse when a request arrives while `ready`=0.
- `lcd_rs` out 1: panel RS.
- `lcd_rw` out 1: panel RW (1 = read).
- `lcd_en` out 1: panel EN.
- `lcd_data_out` out 8: panel data drive value.
- `lcd_data_oe` out 1: panel data output enable.
- `lcd_data_in` in 8: panel data as sampled from the pins.

## Operation
- States: IDLE, SETUP, ENABLE, HOLD, EXEC. `ready` = (state == IDLE), decoded from the registered state.
- Reset values: state IDLE, `ready`=1, `lcd_en`/`lcd_rs`/`lcd_rw`/`lcd_data_oe`=0, `lcd_data_out`=0x00, `rd_data`=0x00, `rd_valid`=0, `overrun`=0.
- Accept: in IDLE, `wr_req` or `rd_req` latches `req_rs`, the direction and `wr_data`, then moves to SETUP. If both are asserted, the write wins and the read is dropped silently, with no `overrun`.
- Request while not IDLE: the request is ignored and `overrun` pulses in the next cycle. Transaction state is unaffected.
- SETUP: `lcd_rs`=latched RS and `lcd_rw`=direction. For writes, `lcd_data_oe`=1 and `lcd_data_out`=byte. For reads, `lcd_data_oe`=0. `lcd_en`=0.
- ENABLE: same as SETUP with `lcd_en`=1. On a read, `lcd_data_in` is captured into `rd_data` on the last ENABLE cycle.
- HOLD: `lcd_en`=0; RS, RW, data and OE are unchanged. A read pulses `rd_valid` in the cycle after the last HOLD cycle and returns to IDLE. A write goes to EXEC.
- EXEC: `lcd_data_oe`=0 and `lcd_rw`=0; `lcd_rs` and `lcd_data_out` keep their values.
  - The wait is `LONG_EXEC_CYCLES` when RS=0, `wr_data[7:2]`=0 and `wr_data[1:0]`≠0 (clear 0x01, home 0x02/0x03).
  - Otherwise the wait is `EXEC_CYCLES`. Command 0x00 uses `EXEC_CYCLES`.
- A single down-counter of width ⌈log2(max parameter+1)⌉ is loaded with N−1 on entry to each timed state. The state advances when the counter reaches 0.
- Reset mid-transaction: the next cycle is IDLE with all outputs at reset values. EN drops immediately, even if this truncates a pulse. No `rd_valid` is produced.

## Timing
- With the accept edge at cycle 0, SETUP occupies cycles 1..S and ENABLE occupies S+1..S+E.
- HOLD occupies S+E+1..S+E+H. EXEC occupies the following X cycles for writes; reads have no EXEC phase.
- Write: `ready`=0 for S+E+H+X cycles, then high. With defaults that is 45 cycles, and `ready` rises in cycle 46.
- Read: `ready`=0 for S+E+H cycles. `rd_valid` pulses in the first cycle that `ready` is back high. With defaults that is cycle 6.
- Back-to-back: a request asserted in the first cycle `ready`=1 is accepted, so there are zero idle cycles between transactions.
- `overrun` and `rd_valid` are registered: one cycle wide, never asserted in consecutive cycles for the same event.

## Test plan
- Reset then write RS=1, 0x41 (defaults) → `lcd_data_oe`=1 and data 0x41 in cycles 1–5; `lcd_en`=1 in cycles 2–4 only; `lcd_rw`=0; `ready` low cycles 1–45, high cycle 46.
- Write RS=0, 0x01 → `ready` low for 1+3+1+1600 = 1605 cycles. Repeat with 0x02 (1605) and 0x00 (45), and with RS=1 data 0x01 (45).
- Read RS=0 with `lcd_data_in`=0x80 during ENABLE (changed to 0x00 in HOLD) → `lcd_rw`=1, `lcd_data_oe`=0; `rd_data`=0x80 with `rd_valid` pulsed in cycle 6; no EXEC.
- `wr_req` and `rd_req` in the same IDLE cycle → write only, no `overrun`. Then `wr_req` in cycle 10 → `overrun` pulse cycle 11, and the transaction still ends at cycle 46.
- Assert `reset` during cycle 3 (EN high) → cycle 4: `lcd_en`=0, `lcd_data_oe`=0, `ready`=1, no `rd_valid`. A new write is then accepted normally.
- Parameters S=E=H=X=1 → a write takes a 4-cycle busy period; two back-to-back writes show EN high in cycles 2 and 7.
